// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: data width, the canonical NOP encoding, fetch FSM states.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding imem requests, one-entry output buffer,
// redirect handling that drops wrong-path responses.
module if_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_valid
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_pc_q;
  logic [XLEN-1:0] r_req_pc;
  logic            r_buf_valid;
  logic [XLEN-1:0] r_buf_pc;
  logic [XLEN-1:0] r_buf_instr;
  logic            w_req;
  logic            w_accept;
  logic            w_take_rsp;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_redirect_pc = redirect_pc & ~32'd3;

  // Issue only when the buffer is free (or drains this cycle), so a response always finds it empty.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req = !redirect_valid && (!r_buf_valid || !stall);
        if (w_req && imem_gnt) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)   w_state_nxt = imem_rvalid ? S_FETCH : S_DISCARD;
        else if (imem_rvalid) w_state_nxt = S_FETCH;
      end
      S_DISCARD: begin
        if (imem_rvalid) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  assign imem_req   = resetn && w_req;
  assign imem_addr  = r_pc_q;
  assign w_accept   = imem_req && imem_gnt;
  assign w_take_rsp = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_FETCH;
      r_pc_q      <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_buf_valid <= 1'b0;
      r_buf_pc    <= '0;
      r_buf_instr <= NOP;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_req_pc <= r_pc_q;
      if (redirect_valid) begin
        r_pc_q      <= w_redirect_pc;
        r_buf_valid <= 1'b0;
      end else if (w_take_rsp) begin
        r_buf_valid <= 1'b1;
        r_buf_pc    <= r_req_pc;
        r_buf_instr <= imem_rdata;
        r_pc_q      <= r_req_pc + 32'd4;
      end else if (r_buf_valid && !stall) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  // A redirect kills the presented instruction in the same cycle.
  assign if_valid = resetn && r_buf_valid && !redirect_valid;
  assign if_instr = if_valid ? r_buf_instr : NOP;
  assign if_pc    = resetn ? r_buf_pc : '0;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: fetch sequencing, stall, redirects, PC wrap, reset abort.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] NOPV = 32'h0000_0013;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .resetn(resetn), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; imem_gnt = 1'b1;
    step; step; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%h exp=0", imem_req); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", if_valid); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", if_pc); end
    total++; if (if_instr !== NOPV) begin bad++; $display("FAIL rst_instr got=%h exp=%h", if_instr, NOPV); end
  endtask

  task automatic test_fetch;
    resetn = 1'b1; imem_gnt = 1'b1; #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%h exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL addr0 got=%h exp=0", imem_addr); end
    step; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL wait_noreq got=%h exp=0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step; imem_rvalid = 1'b0; #1;
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL f0_valid got=%h exp=1", if_valid); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL f0_pc got=%h exp=0", if_pc); end
    total++; if (if_instr !== 32'h0050_0093) begin bad++; $display("FAIL f0_instr got=%h exp=00500093", if_instr); end
    total++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin bad++; $display("FAIL addr4 got=%h req=%h exp=4 req=1", imem_addr, imem_req); end
    step; #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL f0_consumed got=%h exp=0", if_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h00a0_0113;
    step; imem_rvalid = 1'b0; #1;
    total++; if (if_pc !== 32'h4 || if_valid !== 1'b1) begin bad++; $display("FAIL f1 got pc=%h v=%h exp pc=4 v=1", if_pc, if_valid); end
  endtask

  task automatic test_stall;
    stall = 1'b1; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req0 got=%h exp=0", imem_req); end
    for (int i = 0; i < 3; i++) begin
      step; #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req%0d got=%h exp=0", i + 1, imem_req); end
      total++; if (if_pc !== 32'h4 || if_instr !== 32'h00a0_0113 || if_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold%0d got pc=%h instr=%h v=%h exp pc=4 instr=00a00113 v=1", i, if_pc, if_instr, if_valid);
      end
    end
    stall = 1'b0; #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin bad++; $display("FAIL unstall got req=%h addr=%h exp req=1 addr=8", imem_req, imem_addr); end
    step;
  endtask

  task automatic test_redirect_wait;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL rw_cycle got req=%h v=%h exp 0 0", imem_req, if_valid); end
    step; #1;
    total++; if (imem_addr !== 32'h100 || imem_req !== 1'b0) begin bad++; $display("FAIL rw_target got addr=%h req=%h exp addr=100 req=0", imem_addr, imem_req); end
    redirect_pc = 32'h0000_0181;
    step; redirect_valid = 1'b0; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL discard_noreq got=%h exp=0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
    step; imem_rvalid = 1'b0; #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rw_dropped got=%h exp=0", if_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h180) begin bad++; $display("FAIL rw_refetch got req=%h addr=%h exp req=1 addr=180", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_rvalid;
    step;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; imem_rvalid = 1'b1; imem_rdata = 32'hbad0_0bad; #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rr_cycle got=%h exp=0", if_valid); end
    step; redirect_valid = 1'b0; imem_rvalid = 1'b0; #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rr_dropped got=%h exp=0", if_valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL rr_refetch got req=%h addr=%h exp req=1 addr=200", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_buf;
    step;
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step; imem_rvalid = 1'b0; #1;
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin bad++; $display("FAIL rb_load got v=%h pc=%h exp v=1 pc=200", if_valid, if_pc); end
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; #1;
    total++; if (if_valid !== 1'b0 || if_instr !== NOPV || imem_req !== 1'b0) begin
      bad++; $display("FAIL rb_kill got v=%h instr=%h req=%h exp v=0 instr=00000013 req=0", if_valid, if_instr, imem_req);
    end
    step; stall = 1'b0; redirect_valid = 1'b0; #1;
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      bad++; $display("FAIL rb_after got v=%h req=%h addr=%h exp v=0 req=1 addr=300", if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL wrap_supp got=%h exp=0", imem_req); end
    step; redirect_valid = 1'b0; #1;
    total++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin bad++; $display("FAIL wrap_addr got addr=%h req=%h exp addr=fffffffc req=1", imem_addr, imem_req); end
    step;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0513;
    step; imem_rvalid = 1'b0; #1;
    total++; if (if_pc !== 32'hFFFF_FFFC || if_valid !== 1'b1) begin bad++; $display("FAIL wrap_pc got pc=%h v=%h exp pc=fffffffc v=1", if_pc, if_valid); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h exp=0", imem_addr); end
  endtask

  task automatic test_reset_mid;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
    step; redirect_valid = 1'b0;
    step;
    resetn = 1'b0; #1;
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== NOPV) begin
      bad++; $display("FAIL rm_inreset got req=%h v=%h pc=%h instr=%h exp 0 0 0 00000013", imem_req, if_valid, if_pc, if_instr);
    end
    step;
    resetn = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hbad1_bad1; #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      bad++; $display("FAIL rm_release got req=%h addr=%h v=%h exp req=1 addr=0 v=0", imem_req, imem_addr, if_valid);
    end
    step; imem_rvalid = 1'b0; #1;
    total++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL rm_ignored got v=%h req=%h addr=%h exp v=0 req=1 addr=0", if_valid, imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    step; #1;
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL rm_wait got req=%h v=%h exp 0 0", imem_req, if_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
    step; imem_rvalid = 1'b0; #1;
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0010_0073) begin
      bad++; $display("FAIL rm_new got v=%h pc=%h instr=%h exp v=1 pc=0 instr=00100073", if_valid, if_pc, if_instr);
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_stall;
    test_redirect_wait;
    test_redirect_rvalid;
    test_redirect_buf;
    test_wrap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: resetn  input  1  synchronous active-low reset.
REQ-005 Port: stall  input  1  high = IF/ID not writing this cycle (inverse of ifIdWrite).
REQ-006 Port: redirect_valid  input  1  single-cycle branch/jump taken from EX.
REQ-007 Port: redirect_pc  input  32  target address; bits [1:0] ignored, forced 2'b00.
REQ-008 Port: imem_req  output  1  fetch request.
REQ-009 Port: imem_addr  output  32  fetch address, word aligned.
REQ-010 Port: imem_gnt  input  1  request accepted when imem_req && imem_gnt.
REQ-011 Port: imem_rvalid  input  1  response valid, at least 1 cycle after accept.
REQ-012 Port: imem_rdata  input  32  fetched instruction.
REQ-013 Port: if_pc  output  32  PC of presented instruction, to IF/ID pc input.
REQ-014 Port: if_instr  output  32  presented instruction, to IF/ID instruction input; NOP (32'h0000_0013) when if_valid=0.
REQ-015 Port: if_valid  output  1  presented instruction is real (not a bubble).

Function
REQ-016 At most one imem request SHALL be outstanding.
REQ-017 A one-entry output buffer (buf_valid, buf_pc, buf_instr) SHALL drive if_pc/if_instr/if_valid; consumed in any cycle with buf_valid && !stall.
REQ-018 FSM states: FETCH (imem_req may assert), WAIT (accepted, awaiting rvalid), DISCARD (awaiting rvalid to drop).
REQ-019 FETCH: imem_req = !redirect_valid && (!buf_valid || !stall); imem_addr = pc_q; on accept -> WAIT, latch req_pc = pc_q.
REQ-020 WAIT, rvalid without redirect: buf <= {1, req_pc, imem_rdata}; pc_q <= req_pc + 4; -> FETCH.
REQ-021 Buffer SHALL be empty whenever rvalid arrives in WAIT (guaranteed by REQ-019 issue rule).
REQ-022 Redirect SHALL have priority over stall and rvalid: pc_q <= {redirect_pc[31:2],2'b00}; buf_valid <= 0; if_valid forced 0 and if_instr = NOP combinationally in the redirect cycle.
REQ-023 Redirect in WAIT without rvalid -> DISCARD; with rvalid same cycle -> response dropped, -> FETCH.
REQ-024 Redirect in DISCARD: pc_q updated, remain DISCARD; rvalid in DISCARD: dropped, -> FETCH.
REQ-025 Redirect in FETCH: imem_req suppressed that cycle, no accept; remain FETCH.
REQ-026 Stall SHALL hold the buffer contents and if_pc/if_instr stable; it SHALL NOT cancel an outstanding request.
REQ-027 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-028 imem_req MAY drop before grant only on redirect; imem_addr SHALL be stable while imem_req is high otherwise.
REQ-029 Best-case throughput: one instruction per 2 cycles with 1-cycle memory latency.

Reset
REQ-030 While resetn=0: state=FETCH, pc_q=RESET_PC, buf_valid=0, buf_pc=0, buf_instr=NOP, imem_req=0, if_valid=0, if_pc=0, if_instr=NOP.
REQ-031 Reset mid-request SHALL abandon it; an rvalid in the first FETCH cycle after reset SHALL be ignored.
REQ-032 First imem_req SHALL assert in the first cycle with resetn=1.

Structure
REQ-033 Shared package rv32_pkg SHALL hold the NOP constant, fetch FSM state enum and XLEN=32.
REQ-034 No sub-module; buffer and FSM inline in if_stage.

Verification
REQ-035 Reset release, gnt=1, 1-cycle rvalid, rdata=32'h0050_0093 -> imem_addr 0,4,8 in order; if_pc=0, if_instr=32'h0050_0093, if_valid=1 one cycle after rvalid.
REQ-036 Buffer full (pc 4), stall=1 for 3 cycles -> no imem_req, if_pc=4 stable; stall=0 -> next imem_req addr 8 same cycle.
REQ-037 Redirect to 32'h0000_0103 while in WAIT -> next rvalid dropped, if_valid=0, next imem_addr=32'h0000_0100.
REQ-038 Redirect coincident with rvalid -> data dropped, imem_req next cycle at redirect target, no wrong-path if_valid.
REQ-039 pc_q=32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000.
REQ-040 resetn=0 during WAIT, rvalid arrives after release -> ignored, imem_addr=RESET_PC, if_valid=0 until new response.
